switch_event_sequencer: RTL and testbench

//  Digital timing stage directly upstream of the Switch / Relais device models: turns a loaded list of

---
 rtl/switch_event_sequencer.sv | 147 ++++++++++++++
 tb/tb_switch_event_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_event_sequencer.sv
// Switch event sequencer: holds an ordered list of toggle times and, once armed,
// toggles the switch control level as a run timer reaches each scheduled time.
// sw_ctrl drives the control node of the downstream Switch / Relais model.
module switch_event_sequencer #(
  parameter int DEPTH   = 8,     // schedulable toggle events, power of 2, >= 2
  parameter int TW      = 24,    // time stamp / timer width in clk ticks
  parameter bit INIT_ON = 1'b0   // sw_ctrl level after reset / abort / re-arm
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [TW-1:0]            wr_time,
  input  logic                     arm,
  input  logic                     abort,
  output logic                     sw_ctrl,
  output logic                     busy,
  output logic                     done,
  output logic                     order_err,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [TW-1:0] TMR_MAX  = '1;

  logic [1:0]    state;
  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer;
  logic [TW-1:0] last_time;

  logic          full;
  logic          wr_hs;     // handshake completes (entry may still be rejected)
  logic          wr_ok;     // handshake and time strictly increasing -> entry stored
  logic          start;     // arm honoured this cycle
  logic          fire;      // head time reached: toggle and pop
  logic [TW-1:0] head;

  assign full      = (count == CNT_FULL);
  assign wr_ready  = (state == S_IDLE) && !full;
  assign head      = mem[rd_ptr];

  // abort outranks everything, so it masks every other action this cycle.
  // last_time resets to 0, which makes "> last_time" also enforce the >= 1 rule
  // for the first write after a flush.
  assign wr_hs     = wr_valid && wr_ready && !abort;
  assign wr_ok     = wr_hs && (wr_time > last_time);
  assign start     = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign fire      = (state == S_RUN) && (count != '0) && (timer == head) && !abort;

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pending   = count;

  // Run state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if ((count == '0) || (fire && (count == CNT_ONE))) state <= S_DONE;
        S_DONE:  if (start) state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Run timer. The arm cycle is tick 0, so the first RUN cycle already sits at
  // tick 1; a head time T is then matched in the T-th cycle after arm and the
  // registered toggle shows up T+1 cycles after arm. Saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (abort) begin
      timer <= '0;
    end else if (start) begin
      timer <= TW'(1);
    end else if ((state == S_RUN) && (timer != TMR_MAX)) begin
      timer <= timer + TW'(1);
    end
  end

  // Switch control level: restored on abort / arm, flipped on every fired event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_ctrl <= INIT_ON;
    end else if (abort || start) begin
      sw_ctrl <= INIT_ON;
    end else if (fire) begin
      sw_ctrl <= ~sw_ctrl;
    end
  end

  // FIFO pointers and occupancy. Pushes happen only in IDLE and pops only in
  // RUN, so the two never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + AW'(1);
      count  <= count + CNT_ONE;
    end else if (fire) begin
      rd_ptr <= rd_ptr + AW'(1);
      count  <= count - CNT_ONE;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_time;
  end

  // Ordering tracker and sticky order error. A rejected entry still completes
  // its handshake so the writer never stalls on bad data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_time <= '0;
      order_err <= 1'b0;
    end else if (abort) begin
      last_time <= '0;
      order_err <= 1'b0;
    end else if (wr_ok) begin
      last_time <= wr_time;
    end else if (wr_hs) begin
      order_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_event_sequencer.sv
// Bench for switch_event_sequencer: directed scenarios with hand-computed
// expectations, then random load/arm/run/abort episodes compared each cycle
// against a schedule-based reference model.
module tb_switch_event_sequencer;

  localparam int DEPTH = 8;
  localparam int TW    = 24;
  localparam bit INIT  = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [TW-1:0] wr_time = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          wr_ready, sw_ctrl, busy, done, order_err;
  logic [3:0]    pending;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  switch_event_sequencer #(.DEPTH(DEPTH), .TW(TW), .INIT_ON(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_time(wr_time), .arm(arm), .abort(abort), .sw_ctrl(sw_ctrl),
    .busy(busy), .done(done), .order_err(order_err), .pending(pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Loading phase: a plain list of accepted times. Once armed at edge m_ea the
  // schedule is frozen; an entry T fires at edge m_ea+T, so everything else
  // (level, pending, done) follows from counting fired entries.
  int  m_e = 0, m_ea = 0, m_last = 0;
  bit  m_run = 0, m_oerr = 0;
  int  m_q[$];
  int  m_sched[$];

  function automatic int fired(int at);
    int n = 0;
    foreach (m_sched[i]) if (m_sched[i] <= at - m_ea) n++;
    return n;
  endfunction

  function automatic bit done_at(int at);
    return at >= m_ea + ((m_sched.size() == 0) ? 1 : m_sched[m_sched.size()-1]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; m_run = 0; m_ea = 0; m_last = 0; m_oerr = 0;
      m_q.delete(); m_sched.delete();
    end else begin
      m_e++;
      if (abort) begin
        m_run = 0; m_last = 0; m_oerr = 0;
        m_q.delete(); m_sched.delete();
      end else if (!m_run) begin
        if (wr_valid && m_q.size() < DEPTH) begin
          if (int'(wr_time) > m_last) begin
            m_q.push_back(int'(wr_time));
            m_last = int'(wr_time);
          end else begin
            m_oerr = 1;
          end
        end
        if (arm) begin
          m_run = 1; m_ea = m_e; m_sched = m_q; m_q.delete();
        end
      end else if (arm && done_at(m_e - 1)) begin
        m_ea = m_e;
        m_sched.delete();
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    int n;
    bit d;
    logic e_sw, e_busy, e_done, e_rdy;
    int e_pend;
    if (rst_n) begin
      if (!m_run) begin
        e_sw = INIT; e_busy = 0; e_done = 0;
        e_pend = m_q.size(); e_rdy = (m_q.size() < DEPTH);
      end else begin
        n = fired(m_e);
        d = done_at(m_e);
        e_sw = INIT ^ n[0]; e_busy = !d; e_done = d;
        e_pend = m_sched.size() - n; e_rdy = 0;
      end
      chk("m_sw_ctrl",   32'(sw_ctrl),   32'(e_sw));
      chk("m_busy",      32'(busy),      32'(e_busy));
      chk("m_done",      32'(done),      32'(e_done));
      chk("m_wr_ready",  32'(wr_ready),  32'(e_rdy));
      chk("m_order_err", 32'(order_err), 32'(m_oerr));
      chk("m_pending",   32'(pending),   32'(e_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic do_abort();
    abort = 1; tick(); abort = 0;
  endtask

  task automatic write(input int t);
    wr_valid = 1; wr_time = TW'(t); tick(); wr_valid = 0;
  endtask

  initial begin
    int nw, t, run;

    // reset values
    tick(); tick();
    chk("rst_sw", 32'(sw_ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_pending", 32'(pending), 0);
    rst_n = 1;
    tick();

    // 3,5,10 armed at cycle 0: edges visible at 4, 6, 11
    write(3); write(5); write(10);
    arm = 1; tick(); arm = 0;
    for (int k = 1; k <= 11; k++) begin
      case (k)
        3:  chk("t2_sw_c3", 32'(sw_ctrl), 0);
        4:  begin chk("t2_sw_c4", 32'(sw_ctrl), 1); chk("t2_pend_c4", 32'(pending), 2); end
        5:  chk("t2_sw_c5", 32'(sw_ctrl), 1);
        6:  chk("t2_sw_c6", 32'(sw_ctrl), 0);
        10: begin chk("t2_sw_c10", 32'(sw_ctrl), 0); chk("t2_busy_c10", 32'(busy), 1); end
        11: begin
          chk("t2_sw_c11", 32'(sw_ctrl), 1);
          chk("t2_done_c11", 32'(done), 1);
          chk("t2_busy_c11", 32'(busy), 0);
        end
        default: ;
      endcase
      if (k < 11) tick();
    end
    // re-arm from DONE: level back to INIT, done low for one cycle
    arm = 1; tick(); arm = 0;
    chk("t6_rearm_sw", 32'(sw_ctrl), 0);
    chk("t6_rearm_done", 32'(done), 0);
    chk("t6_rearm_busy", 32'(busy), 1);
    tick();
    chk("t6_rearm_done2", 32'(done), 1);

    // fill to DEPTH, ninth write refused
    do_abort();
    for (int i = 1; i <= DEPTH; i++) write(i);
    chk("t3_pending", 32'(pending), 8);
    chk("t3_ready", 32'(wr_ready), 0);
    write(9);
    chk("t3_pending9", 32'(pending), 8);
    chk("t3_oerr9", 32'(order_err), 0);

    // ordering violation
    do_abort();
    write(5); write(5); write(4);
    chk("t4_pending", 32'(pending), 1);
    chk("t4_oerr", 32'(order_err), 1);
    do_abort();
    chk("t4_oerr_clr", 32'(order_err), 0);
    chk("t4_pend_clr", 32'(pending), 0);

    // abort mid-run
    write(4); write(8);
    arm = 1; tick(); arm = 0;
    repeat (4) tick();
    chk("t5_sw_c5", 32'(sw_ctrl), 1);
    tick();
    abort = 1; tick(); abort = 0;
    chk("t5_sw_c7", 32'(sw_ctrl), 0);
    chk("t5_busy_c7", 32'(busy), 0);
    chk("t5_ready_c7", 32'(wr_ready), 1);
    tick(); tick();
    chk("t5_sw_c9", 32'(sw_ctrl), 0);
    tick();
    chk("t5_sw_c10", 32'(sw_ctrl), 0);

    // empty arm from IDLE
    do_abort();
    arm = 1; tick(); arm = 0;
    chk("t6_busy_c1", 32'(busy), 1);
    tick();
    chk("t6_done_c2", 32'(done), 1);
    chk("t6_sw_c2", 32'(sw_ctrl), 0);

    // async reset mid-run
    do_abort();
    write(2); write(6);
    arm = 1; tick(); arm = 0;
    repeat (3) tick();
    chk("t1_sw_before", 32'(sw_ctrl), 1);
    #2 rst_n = 0;
    #1;
    chk("t1_sw", 32'(sw_ctrl), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_pending", 32'(pending), 0);
    chk("t1_ready", 32'(wr_ready), 1);
    tick();
    rst_n = 1;
    tick();

    // random episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_abort();
      nw = int'($urandom_range(0, 10));
      t = 0;
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          tick();
        end else begin
          t = t + int'($urandom_range(0, 6));
          wr_valid = 1;
          wr_time = TW'(t);
          arm = (i == nw - 1) && ($urandom_range(0, 1) == 1);
          tick();
          wr_valid = 0;
          arm = 0;
        end
      end
      arm = 1; tick(); arm = 0;
      run = int'($urandom_range(1, 70));
      for (int j = 0; j < run; j++) begin
        arm = ($urandom_range(0, 7) == 0);
        abort = ($urandom_range(0, 49) == 0);
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_time = TW'($urandom_range(0, 60));
        tick();
      end
      arm = 0; abort = 0; wr_valid = 0;
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
